// File: rtl/game_pkg.sv
// Shared encodings and BCD helpers for the shooting game.
// Used by the round sequencer and the display path.
package game_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_COUNTDOWN = 2'd1;
   localparam logic [1:0] ST_PLAY      = 2'd2;
   localparam logic [1:0] ST_OVER      = 2'd3;

   typedef logic [3:0] bcd_t;

   function automatic logic [7:0] bcd_dec(input logic [7:0] t);
      bcd_t tens;
      bcd_t ones;
      tens = t[7:4];
      ones = t[3:0];
      if (ones == 4'd0) begin
         ones = 4'd9;
         tens = tens - 4'd1;
      end else begin
         ones = ones - 4'd1;
      end
      return {tens, ones};
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/game_round_ctrl_sec_tick_gen.sv
// One-second tick prescaler with synchronous clear.
// Tick is high while the count sits on its last value.
module sec_tick_gen #(
   parameter int CLK_HZ = 100000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   // wrap at LAST, restart from zero on clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: countdown, round timer, shot conditioning
// and goal qualification feeding the score counter.
module game_round_ctrl #(
   parameter int CLK_HZ        = 100000000,
   parameter int COUNTDOWN_SEC = 3,
   parameter int ROUND_SEC     = 60,
   parameter int BONUS_SEC     = 10,
   parameter int LOCKOUT_CYC   = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       shot_in,
   output logic       dis_score,
   output logic       goal,
   output logic       two,
   output logic [3:0] time_tens,
   output logic [3:0] time_ones,
   output logic [1:0] state,
   output logic       game_over
);

   import game_pkg::*;

   localparam logic [7:0] CD_BCD  = to_bcd(COUNTDOWN_SEC);
   localparam logic [7:0] RND_BCD = to_bcd(ROUND_SEC);
   localparam logic [7:0] BON_BCD = to_bcd(BONUS_SEC);
   localparam int LK_W = $clog2(LOCKOUT_CYC + 1);

   logic [1:0]      st;
   logic [7:0]      tm;
   logic            s1, s2, s3;
   logic [LK_W-1:0] lock;
   logic            tick;
   logic            abort_ok;
   logic            enter_cd;
   logic            rise;
   logic            in_play;
   logic            acc;
   logic            last_sec;

   assign abort_ok = abort & (st != ST_IDLE);
   assign enter_cd = start & ~abort_ok
                   & ((st == ST_IDLE) | (st == ST_OVER));
   assign rise     = s2 & ~s3;
   assign in_play  = (st == ST_PLAY);
   assign acc      = rise & in_play & (lock == '0) & ~abort_ok;
   assign last_sec = (tm == 8'h01);

   assign state     = st;
   assign time_tens = tm[7:4];
   assign time_ones = tm[3:0];
   assign dis_score = (st == ST_PLAY) | (st == ST_OVER);
   assign game_over = (st == ST_OVER);

   sec_tick_gen #(
      .CLK_HZ(CLK_HZ)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (enter_cd),
      .tick (tick)
   );

   // two-flop synchronizer plus edge-history flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= shot_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // round state and BCD time; abort overrides everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= ST_IDLE;
         tm <= RND_BCD;
      end else if (abort_ok) begin
         st <= ST_IDLE;
         tm <= RND_BCD;
      end else if (enter_cd) begin
         st <= ST_COUNTDOWN;
         tm <= CD_BCD;
      end else begin
         unique case (1'b1)
            (st == ST_COUNTDOWN): begin
               if (tick && last_sec) begin
                  st <= ST_PLAY;
                  tm <= RND_BCD;
               end else if (tick) begin
                  tm <= bcd_dec(tm);
               end
            end
            (st == ST_PLAY): begin
               if (tick && last_sec) begin
                  st <= ST_OVER;
                  tm <= 8'h00;
               end else if (tick) begin
                  tm <= bcd_dec(tm);
               end
            end
            default: ;
         endcase
      end
   end

   // goal pulse, bonus flag from pre-decrement time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         goal <= 1'b0;
         two  <= 1'b0;
      end else begin
         goal <= acc;
         two  <= acc & (tm <= BON_BCD);
      end
   end

   // post-goal lockout, cleared whenever not playing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock <= '0;
      end else if (acc) begin
         lock <= LK_W'(LOCKOUT_CYC);
      end else if (!in_play) begin
         lock <= '0;
      end else if (lock != '0) begin
         lock <= lock - LK_W'(1);
      end
   end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl.
// Small clock divider so whole rounds fit in a few hundred cycles.
module tb_game_round_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       shot_in;
   logic       dis_score;
   logic       goal;
   logic       two;
   logic [3:0] time_tens;
   logic [3:0] time_ones;
   logic [1:0] state;
   logic       game_over;

   int nvec;
   int nerr;

   game_round_ctrl #(
      .CLK_HZ       (10),
      .COUNTDOWN_SEC(3),
      .ROUND_SEC    (12),
      .BONUS_SEC    (5),
      .LOCKOUT_CYC  (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .shot_in  (shot_in),
      .dis_score(dis_score),
      .goal     (goal),
      .two      (two),
      .time_tens(time_tens),
      .time_ones(time_ones),
      .state    (state),
      .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [13:0] obs;
   assign obs = {state, dis_score, game_over, goal, two,
                 time_tens, time_ones};

   function automatic logic [13:0] pk(input logic [1:0] st,
                                      input logic d,
                                      input logic g,
                                      input logic gl,
                                      input logic tw,
                                      input logic [7:0] t);
      return {st, d, g, gl, tw, t};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step(2);
      nvec++;
      if (obs !== pk(2'd0, 0, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL reset_held got %h want %h",
                  obs, pk(2'd0, 0, 0, 0, 0, 8'h12));
      end
      rst_n = 1'b1;
      step(1);
      nvec++;
      if (obs !== pk(2'd0, 0, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL reset_released got %h want %h",
                  obs, pk(2'd0, 0, 0, 0, 0, 8'h12));
      end
   endtask

   task automatic test_countdown;
      start = 1'b1;
      step(1);
      start = 1'b0;
      nvec++;
      if (obs !== pk(2'd1, 0, 0, 0, 0, 8'h03)) begin
         nerr++;
         $display("FAIL cd_entry got %h want %h",
                  obs, pk(2'd1, 0, 0, 0, 0, 8'h03));
      end
      step(9);
      nvec++;
      if (obs !== pk(2'd1, 0, 0, 0, 0, 8'h03)) begin
         nerr++;
         $display("FAIL cd_pre_tick got %h want %h",
                  obs, pk(2'd1, 0, 0, 0, 0, 8'h03));
      end
      step(1);
      nvec++;
      if (obs !== pk(2'd1, 0, 0, 0, 0, 8'h02)) begin
         nerr++;
         $display("FAIL cd_first_tick got %h want %h",
                  obs, pk(2'd1, 0, 0, 0, 0, 8'h02));
      end
      step(20);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL play_entry got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h12));
      end
   endtask

   task automatic test_bcd_steps;
      step(10);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h11)) begin
         nerr++;
         $display("FAIL play_11 got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h11));
      end
      step(10);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h10)) begin
         nerr++;
         $display("FAIL play_10 got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h10));
      end
      step(10);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h09)) begin
         nerr++;
         $display("FAIL play_09 got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h09));
      end
   endtask

   task automatic test_lockout;
      // c60 now; time 08 from c70
      step(10);
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      step(1);
      nvec++;
      if (goal !== 1'b0) begin
         nerr++;
         $display("FAIL goal_early got %b want 0", goal);
      end
      step(1);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 1, 0, 8'h08)) begin
         nerr++;
         $display("FAIL goal_08 got %h want %h",
                  obs, pk(2'd2, 1, 0, 1, 0, 8'h08));
      end
      // c73: second edge lands while lockout is active
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (goal !== 1'b0) begin
            nerr++;
            $display("FAIL lockout_ignore c%0d got %b want 0",
                     74 + i, goal);
         end
         step(1);
      end
      // c77: edge after lockout expires
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      step(2);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 1, 0, 8'h07)) begin
         nerr++;
         $display("FAIL goal_relock got %h want %h",
                  obs, pk(2'd2, 1, 0, 1, 0, 8'h07));
      end
      step(1);
      nvec++;
      if ({goal, two} !== 2'b00) begin
         nerr++;
         $display("FAIL goal_one_cycle got %b want 00",
                  {goal, two});
      end
   endtask

   task automatic test_bonus;
      // c81 -> c90, time 06
      step(9);
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      step(2);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 1, 0, 8'h06)) begin
         nerr++;
         $display("FAIL goal_06 got %h want %h",
                  obs, pk(2'd2, 1, 0, 1, 0, 8'h06));
      end
      // c93 -> c100, time 05
      step(7);
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      step(2);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 1, 1, 8'h05)) begin
         nerr++;
         $display("FAIL goal_05 got %h want %h",
                  obs, pk(2'd2, 1, 0, 1, 1, 8'h05));
      end
      step(37);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h01)) begin
         nerr++;
         $display("FAIL play_01 got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h01));
      end
      // edge detected in the final tick cycle c149
      step(7);
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      step(2);
      nvec++;
      if (obs !== pk(2'd3, 1, 1, 1, 1, 8'h00)) begin
         nerr++;
         $display("FAIL goal_final_tick got %h want %h",
                  obs, pk(2'd3, 1, 1, 1, 1, 8'h00));
      end
      step(1);
      nvec++;
      if (obs !== pk(2'd3, 1, 1, 0, 0, 8'h00)) begin
         nerr++;
         $display("FAIL over_hold got %h want %h",
                  obs, pk(2'd3, 1, 1, 0, 0, 8'h00));
      end
   endtask

   task automatic test_discard_over;
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nvec++;
         if (goal !== 1'b0) begin
            nerr++;
            $display("FAIL over_shot c%0d got %b want 0", i, goal);
         end
         step(1);
      end
   endtask

   task automatic test_restart;
      start = 1'b1;
      step(1);
      start = 1'b0;
      nvec++;
      if (obs !== pk(2'd1, 0, 0, 0, 0, 8'h03)) begin
         nerr++;
         $display("FAIL restart got %h want %h",
                  obs, pk(2'd1, 0, 0, 0, 0, 8'h03));
      end
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nvec++;
         if (goal !== 1'b0) begin
            nerr++;
            $display("FAIL cd_shot c%0d got %b want 0", i, goal);
         end
         step(1);
      end
      // c6 -> c30
      step(24);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL restart_play got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h12));
      end
      start = 1'b1;
      step(1);
      start = 1'b0;
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL start_in_play got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h12));
      end
      step(9);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h11)) begin
         nerr++;
         $display("FAIL start_no_effect got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h11));
      end
   endtask

   task automatic test_abort;
      // c40 -> c80, time 07
      step(40);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h07)) begin
         nerr++;
         $display("FAIL pre_abort got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h07));
      end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      nvec++;
      if (obs !== pk(2'd0, 0, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL abort_idle got %h want %h",
                  obs, pk(2'd0, 0, 0, 0, 0, 8'h12));
      end
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nvec++;
         if (goal !== 1'b0) begin
            nerr++;
            $display("FAIL idle_shot c%0d got %b want 0", i, goal);
         end
         step(1);
      end
   endtask

   task automatic test_abort_vs_goal;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(30);
      nvec++;
      if (state !== 2'd2) begin
         nerr++;
         $display("FAIL avg_play got %0d want 2", state);
      end
      shot_in = 1'b1;
      step(1);
      shot_in = 1'b0;
      step(1);
      // edge is live now; abort in the same cycle
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      nvec++;
      if (obs !== pk(2'd0, 0, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL abort_vs_goal got %h want %h",
                  obs, pk(2'd0, 0, 0, 0, 0, 8'h12));
      end
      step(1);
      nvec++;
      if (goal !== 1'b0) begin
         nerr++;
         $display("FAIL abort_vs_goal_late got %b want 0", goal);
      end
   endtask

   task automatic test_async_reset;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(35);
      nvec++;
      if (obs !== pk(2'd2, 1, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL ar_play got %h want %h",
                  obs, pk(2'd2, 1, 0, 0, 0, 8'h12));
      end
      #2;
      rst_n = 1'b0;
      #1;
      nvec++;
      if (obs !== pk(2'd0, 0, 0, 0, 0, 8'h12)) begin
         nerr++;
         $display("FAIL async_reset got %h want %h",
                  obs, pk(2'd0, 0, 0, 0, 0, 8'h12));
      end
      step(1);
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      nvec    = 0;
      nerr    = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      shot_in = 1'b0;
      test_reset();
      test_countdown();
      test_bcd_steps();
      test_lockout();
      test_bonus();
      test_discard_over();
      test_restart();
      test_abort();
      test_abort_vs_goal();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
